ins2sp_win: RTL
===============

Name: ins2sp_win

Overview:
- Parametrised successor to the per-field switching-activity counter. Takes CH packed data channels of DW bits each.
- Each valid sample: counts bit toggles against that channel's previous sample, per enabled channel, and sums across channels into an instantaneous toggle count.
- Accumulates counts over a programmable window of valid samples; reports window total (saturating), window peak and saturation flag.
- Sits after the instruction-field capture stage, feeding the power-estimation readout.

Parameters:
- CH, 6, number of data channels.
- DW, 32, bits per channel.
- CW, 16, width of window accumulator and o_sp_acc.
- LW, 8, width of window-length input.
- SW (localparam), $clog2(CH*DW+1), width of instantaneous count and peak (defaults give 8).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  sample strobe; i_data is sampled when high.
- i_data  input  CH*DW  packed channels; channel k = bits [k*DW +: DW].
- i_mask  input  CH  per-channel enable; 0 = channel contributes 0 toggles.
- i_win_len  input  LW  window length in valid samples; 0 is treated as 1.
- i_clear  input  1  synchronous soft clear.
- o_inst_valid  output  1  high the cycle after each accepted sample.
- o_sp_inst  output  SW  toggle count of last accepted sample.
- o_acc_valid  output  1  one-cycle pulse: window complete.
- o_sp_acc  output  CW  window toggle total, saturated at 2^CW-1.
- o_peak  output  SW  maximum o_sp_inst value within the reported window.
- o_sat  output  1  window accumulator saturated during reported window.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0.
  - prev registers 0; primed=0; window counter 0; accumulator 0; running peak 0; sticky sat 0.
- Sample acceptance: i_valid=1 and i_clear=0 at rising edge.
- Toggle count per channel k: popcount(i_data[k] XOR prev[k]) if i_mask[k]=1 and primed=1, else 0.
  - pop = sum over channels, SW bits, never overflows.
- prev update:
  - On every accepted sample, prev[k] <= i_data[k] for all channels, masked or not, so unmasking produces no spurious toggles.
  - primed <= 1 on the first accepted sample after reset or clear. That first sample contributes pop=0 but still counts as a window sample.
- Latency: sample at edge t → o_inst_valid=1 and o_sp_inst=pop visible after edge t, for one cycle. o_inst_valid=0 otherwise; o_sp_inst holds its value.
- Window length:
  - wl = max(i_win_len,1), latched at the first sample of each window.
  - Changes mid-window take effect at the next window.
- Window counting: each accepted sample increments the window counter; acc_next = min(acc+pop, 2^CW-1); sticky sat set if acc+pop > 2^CW-1; running peak = max(peak, pop).
- Window end, when the accepted sample is number wl:
  - After the same edge: o_acc_valid=1 for one cycle, o_sp_acc=acc_next, o_peak=final peak including this sample, o_sat=final sticky.
  - Internal acc, peak, sat and counter return to 0 on that edge. The next sample starts a new window with no idle gap.
  - o_sp_acc, o_peak and o_sat hold until the next window end, clear or reset.
- i_clear=1:
  - Next edge: acc, counter, peak, sat, primed all 0; o_acc_valid=0; o_inst_valid=0.
  - Held outputs o_sp_acc, o_peak, o_sat, o_sp_inst become 0.
  - Clear wins over a simultaneous i_valid; that sample is discarded and prev is not updated.
- wl=1: every accepted sample produces o_acc_valid the next cycle, with o_sp_acc = o_peak = pop.
- Back-to-back valids are fully supported at one sample per cycle; no backpressure.
- Reset asserted mid-window: window is lost and no o_acc_valid is generated.

Test Plan:
- Prime test. CH=2, DW=8, mask=11, win_len=4; samples {00,00}, {FF,00}, {FF,0F}, {00,0F}.
  - o_sp_inst = 0, 8, 4, 8.
  - o_acc_valid one cycle after 4th sample, o_sp_acc=20, o_peak=8, o_sat=0.
- Mask test. Same stream with mask=01 (channel 0 only).
  - o_sp_inst = 0, 8, 0, 8; o_sp_acc=16.
  - Then unmask with an unchanged sample: o_sp_inst=0.
- Saturation test. CW=4, DW=8, CH=1, win_len=3; alternate 00/FF.
  - Window sums 0+8+8=16 → o_sp_acc=15, o_sat=1.
  - Next window of alternating samples: 8+8+8 → 15, o_sat=1.
  - Then a window of constant samples → o_sp_acc=0, o_sat=0.
- Window-length test.
  - win_len=0: o_acc_valid pulses after every sample.
  - win_len changed 4→2 mid-window: current window still ends after 4 samples, the next after 2.
- Clear test. Assert i_clear together with i_valid mid-window.
  - Next cycle: all outputs 0 and o_inst_valid=0.
  - Next sample produces pop=0 (re-prime); window count restarts at 1.
- Reset test. Drop rst_n asynchronously between edges mid-window.
  - All outputs 0 immediately.
  - After release, no o_acc_valid until a full new window of win_len samples.

Source files
------------

// File: rtl/ins2sp_win.sv
// ins2sp_win -- windowed switching-activity counter.
//
// Counts bit toggles between consecutive accepted samples on CH packed
// channels of DW bits each. Per-sample counts are summed over the enabled
// channels and reported as o_sp_inst. They are also accumulated over a
// programmable window of accepted samples. At the end of each window the
// bench/readout sees the saturating total, the peak per-sample count and
// a sticky saturation flag.
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   i_valid       sample strobe (accepted when i_clear is low)
//   i_data        CH*DW packed channels, channel k = [k*DW +: DW]
//   i_mask        per-channel enable (0 = channel contributes no toggles)
//   i_win_len     window length in accepted samples, 0 behaves as 1
//   i_clear       synchronous soft clear, wins over i_valid
//   o_inst_valid  one-cycle strobe after each accepted sample
//   o_sp_inst     toggle count of the last accepted sample
//   o_acc_valid   one-cycle strobe when a window completes
//   o_sp_acc      window toggle total, saturated at 2^CW-1
//   o_peak        maximum o_sp_inst within the reported window
//   o_sat         accumulator saturated during the reported window
module ins2sp_win #(
  parameter  int CH = 6,
  parameter  int DW = 32,
  parameter  int CW = 16,
  parameter  int LW = 8,
  localparam int SW = $clog2(CH*DW+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [CH*DW-1:0] i_data,
  input  logic [CH-1:0]    i_mask,
  input  logic [LW-1:0]    i_win_len,
  input  logic             i_clear,
  output logic             o_inst_valid,
  output logic [SW-1:0]    o_sp_inst,
  output logic             o_acc_valid,
  output logic [CW-1:0]    o_sp_acc,
  output logic [SW-1:0]    o_peak,
  output logic             o_sat
);

  // Sum width wide enough that acc + pop can never wrap before comparison.
  localparam int AW = ((CW > SW) ? CW : SW) + 1;
  localparam logic [AW-1:0] ACC_MAX = AW'({CW{1'b1}});

  logic [CH*DW-1:0] prev_q;
  logic             primed_q;
  logic [LW-1:0]    cnt_q;
  logic [LW-1:0]    wl_q;
  logic [CW-1:0]    acc_q;
  logic [SW-1:0]    peak_q;
  logic             sat_q;

  logic             inst_valid_q;
  logic [SW-1:0]    sp_inst_q;
  logic             acc_valid_q;
  logic [CW-1:0]    sp_acc_q;
  logic [SW-1:0]    peak_out_q;
  logic             sat_out_q;

  logic [CH*DW-1:0] diff;
  logic [SW-1:0]    pop_d;
  logic [LW-1:0]    wl_d;
  logic [LW-1:0]    cnt_inc;
  logic             win_end;
  logic [AW-1:0]    sum_w;
  logic             over;
  logic [CW-1:0]    acc_d;
  logic [SW-1:0]    peak_d;
  logic             sat_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    diff  = i_data ^ prev_q;
    pop_d = '0;
    for (int k = 0; k < CH; k++) begin
      if (i_mask[k] && primed_q) begin
        for (int b = 0; b < DW; b++) begin
          pop_d = pop_d + SW'(diff[k*DW+b]);
        end
      end
    end

    // Window length is captured only on the first sample of a window, so
    // mid-window changes apply to the following window.
    if (cnt_q == '0) begin
      wl_d = (i_win_len == '0) ? LW'(1) : i_win_len;
    end else begin
      wl_d = wl_q;
    end
    cnt_inc = cnt_q + LW'(1);
    win_end = (cnt_inc == wl_d);

    sum_w  = AW'(acc_q) + AW'(pop_d);
    over   = (sum_w > ACC_MAX);
    acc_d  = over ? {CW{1'b1}} : sum_w[CW-1:0];
    sat_d  = sat_q | over;
    peak_d = (pop_d > peak_q) ? pop_d : peak_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: prev is reset too: it feeds a datapath compare, and a known value keeps reset behaviour deterministic.
      prev_q       <= '0;
      primed_q     <= 1'b0;
      cnt_q        <= '0;
      wl_q         <= '0;
      acc_q        <= '0;
      peak_q       <= '0;
      sat_q        <= 1'b0;
      inst_valid_q <= 1'b0;
      sp_inst_q    <= '0;
      acc_valid_q  <= 1'b0;
      sp_acc_q     <= '0;
      peak_out_q   <= '0;
      sat_out_q    <= 1'b0;
    end else begin
      inst_valid_q <= 1'b0;
      acc_valid_q  <= 1'b0;
      if (i_clear) begin
        // prev is deliberately left alone; primed=0 masks it on the next sample.
        primed_q   <= 1'b0;
        cnt_q      <= '0;
        acc_q      <= '0;
        peak_q     <= '0;
        sat_q      <= 1'b0;
        sp_inst_q  <= '0;
        sp_acc_q   <= '0;
        peak_out_q <= '0;
        sat_out_q  <= 1'b0;
      end else if (i_valid) begin
        // All channels update, masked or not, so unmasking never sees stale data.
        prev_q       <= i_data;
        primed_q     <= 1'b1;
        inst_valid_q <= 1'b1;
        sp_inst_q    <= pop_d;
        wl_q         <= wl_d;
        if (win_end) begin
          acc_valid_q <= 1'b1;
          sp_acc_q    <= acc_d;
          peak_out_q  <= peak_d;
          sat_out_q   <= sat_d;
          cnt_q       <= '0;
          acc_q       <= '0;
          peak_q      <= '0;
          sat_q       <= 1'b0;
        end else begin
          cnt_q  <= cnt_inc;
          acc_q  <= acc_d;
          peak_q <= peak_d;
          sat_q  <= sat_d;
        end
      end
    end
  end

  assign o_inst_valid = inst_valid_q;
  assign o_sp_inst    = sp_inst_q;
  assign o_acc_valid  = acc_valid_q;
  assign o_sp_acc     = sp_acc_q;
  assign o_peak       = peak_out_q;
  assign o_sat        = sat_out_q;

endmodule
